// File: rtl/pwm_fader.sv
// Multi-channel PWM LED fader: hue-wheel ramping across six phases or static per-channel duty.
// Duty registers update only at period boundaries so a PWM period is never disturbed mid-way.
module pwm_fader #(
  parameter int NUM_CH       = 3,
  parameter int PWM_INTERVAL = 1200,
  parameter int STEP_SIZE    = 12,
  parameter int ACTIVE_LOW   = 1,
  localparam int DW          = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [NUM_CH*DW-1:0] static_duty,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 period_tick
);

  localparam int STEPS = PWM_INTERVAL / STEP_SIZE;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [DW:0]   FULL_W    = (DW+1)'(PWM_INTERVAL);
  localparam logic [DW:0]   STEP_W    = (DW+1)'(STEP_SIZE);
  localparam logic [DW-1:0] FULL      = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] LAST      = DW'(PWM_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);
  localparam logic          INACTIVE  = (ACTIVE_LOW != 0);

  generate
    if (PWM_INTERVAL % STEP_SIZE != 0) begin : g_bad_step
      $error("pwm_fader: PWM_INTERVAL must be a multiple of STEP_SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {ST_UP, ST_HI, ST_DOWN, ST_LO} ch_state_t;

  // Channels are spread 120 degrees apart around the six-phase wheel.
  function automatic ch_state_t state_of(input logic [2:0] ph, input int unsigned k);
    logic [3:0] idx;
    idx = (4'(ph) + 4'd6 - 4'(32'd2 * (k % 32'd3))) % 4'd6;
    case (idx)
      4'd0:       state_of = ST_UP;
      4'd1, 4'd2: state_of = ST_HI;
      4'd3:       state_of = ST_DOWN;
      default:    state_of = ST_LO;
    endcase
  endfunction

  function automatic logic [DW-1:0] entry_level(input ch_state_t s);
    if (s == ST_HI || s == ST_DOWN) entry_level = FULL;
    else                            entry_level = {DW{1'b0}};
  endfunction

  function automatic logic [DW-1:0] ramp_up(input logic [DW-1:0] d);
    logic [DW:0] s;
    s = {1'b0, d} + STEP_W;
    if (s > FULL_W) ramp_up = FULL;
    else            ramp_up = s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] ramp_down(input logic [DW-1:0] d);
    if ({1'b0, d} < STEP_W) ramp_down = {DW{1'b0}};
    else                    ramp_down = d - STEP_W[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] v);
    if ({1'b0, v} > FULL_W) clamp = FULL;
    else                    clamp = v;
  endfunction

  logic [DW-1:0]     pwm_cnt_r;
  logic [SW-1:0]     step_cnt_r;
  logic [2:0]        phase_r;
  logic [DW-1:0]     duty_r      [NUM_CH];
  logic [DW-1:0]     duty_next_s [NUM_CH];
  logic [DW-1:0]     duty_rst_s  [NUM_CH];
  logic [NUM_CH-1:0] level_s;
  logic              boundary_s;
  logic              phase_adv_s;
  logic [2:0]        phase_next_s;

  // Boundary detection, next phase and the duty each channel takes at the next boundary.
  always_comb begin
    boundary_s  = en && (pwm_cnt_r == LAST);
    phase_adv_s = !mode && (step_cnt_r == STEP_LAST);
    if (phase_r == 3'd5) phase_next_s = 3'd0;
    else                 phase_next_s = phase_r + 3'd1;
    for (int k = 0; k < NUM_CH; k++) begin
      duty_rst_s[k] = entry_level(state_of(3'd0, k));
      level_s[k]    = (pwm_cnt_r < duty_r[k]) ^ INACTIVE;
      if (mode) begin
        duty_next_s[k] = clamp(static_duty[k*DW +: DW]);
      end else if (phase_adv_s) begin
        duty_next_s[k] = entry_level(state_of(phase_next_s, k));
      end else begin
        case (state_of(phase_r, k))
          ST_UP:   duty_next_s[k] = ramp_up(duty_r[k]);
          ST_DOWN: duty_next_s[k] = ramp_down(duty_r[k]);
          ST_HI:   duty_next_s[k] = FULL;
          ST_LO:   duty_next_s[k] = {DW{1'b0}};
          default: duty_next_s[k] = duty_r[k];
        endcase
      end
    end
  end

  // Counters, duty registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_r   <= {DW{1'b0}};
      step_cnt_r  <= {SW{1'b0}};
      phase_r     <= 3'd0;
      period_tick <= 1'b0;
      pwm_out     <= {NUM_CH{INACTIVE}};
      for (int k = 0; k < NUM_CH; k++) duty_r[k] <= duty_rst_s[k];
    end else begin
      period_tick <= boundary_s;
      pwm_out     <= en ? level_s : {NUM_CH{INACTIVE}};
      if (boundary_s) begin
        pwm_cnt_r <= {DW{1'b0}};
        for (int k = 0; k < NUM_CH; k++) duty_r[k] <= duty_next_s[k];
        // Static mode freezes the wheel position so fading resumes where it left off.
        if (!mode) begin
          if (step_cnt_r == STEP_LAST) begin
            step_cnt_r <= {SW{1'b0}};
            phase_r    <= phase_next_s;
          end else begin
            step_cnt_r <= step_cnt_r + SW'(1);
          end
        end
      end else if (en) begin
        pwm_cnt_r <= pwm_cnt_r + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_fader.sv
// Bench for pwm_fader: per-cycle comparison against a period-level behavioural model,
// plus hand-computed low-clock counts per period for the directed scenarios.
module tb_pwm_fader;

  localparam int PI = 8;
  localparam int SS = 2;
  localparam int STEPS = PI / SS;

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [11:0] sd3;
  logic [15:0] sd4;
  logic [2:0]  pwm3;
  logic        tick3;
  logic [3:0]  pwm4;
  logic        tick4;
  logic        chk_en = 1'b0;

  always #5 clk = ~clk;

  pwm_fader #(.NUM_CH(3), .PWM_INTERVAL(PI), .STEP_SIZE(SS), .ACTIVE_LOW(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .static_duty(sd3),
    .pwm_out(pwm3), .period_tick(tick3));

  pwm_fader #(.NUM_CH(4), .PWM_INTERVAL(PI), .STEP_SIZE(SS), .ACTIVE_LOW(1)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .static_duty(sd4),
    .pwm_out(pwm4), .period_tick(tick4));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: wheel position is the count of fading periods completed.
  int pat[6] = '{0, 1, 1, 2, 3, 3};   // 0 UP, 1 HI, 2 DOWN, 3 LO
  int sdv[4] = '{3, 15, 0, 3};
  int m_cnt, m_total;
  int m_duty[4];
  logic [3:0] exp_out;
  logic       exp_tick;

  function automatic int st(input int ph, input int k);
    return pat[(ph - 2 * k + 12) % 6];
  endfunction

  function automatic int start_duty(input int s);
    return (s == 1 || s == 2) ? PI : 0;
  endfunction

  task automatic model_boundary();
    int old_ph, new_ph, s;
    if (mode) begin
      for (int k = 0; k < 4; k++) m_duty[k] = (sdv[k] > PI) ? PI : sdv[k];
    end else begin
      old_ph = (m_total / STEPS) % 6;
      m_total++;
      new_ph = (m_total / STEPS) % 6;
      for (int k = 0; k < 4; k++) begin
        s = st(new_ph, k);
        if (new_ph != old_ph) m_duty[k] = start_duty(s);
        else if (s == 0) m_duty[k] = (m_duty[k] + SS > PI) ? PI : m_duty[k] + SS;
        else if (s == 2) m_duty[k] = (m_duty[k] < SS) ? 0 : m_duty[k] - SS;
        else m_duty[k] = start_duty(s);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_cnt = 0;
        m_total = 0;
        for (int k = 0; k < 4; k++) m_duty[k] = start_duty(st(0, k));
        exp_out = 4'b1111;
        exp_tick = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) exp_out[k] = en ? !(m_cnt < m_duty[k]) : 1'b1;
        exp_tick = en && (m_cnt == PI - 1);
        if (en) begin
          if (m_cnt == PI - 1) begin
            m_cnt = 0;
            model_boundary();
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out3", 32'(pwm3), 32'(exp_out[2:0]));
      check("tick3", 32'(tick3), 32'(exp_tick));
      check("out4", 32'(pwm4), 32'(exp_out));
      check("tick4", 32'(tick4), 32'(exp_tick));
      check("ch3_follows_ch0", 32'(pwm4[3]), 32'(pwm4[0]));
    end
  end

  int lows[3];

  task automatic count_period();
    for (int k = 0; k < 3; k++) lows[k] = 0;
    repeat (PI) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (pwm3[k] == 1'b0) lows[k]++;
    end
  endtask

  task automatic wait_tick();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (tick3 === 1'b1) ok = 1'b1;
    end
    check("tick_wait", 32'(ok), 32'd1);
  endtask

  // Low clocks per period for periods 1..25 after reset.
  int tab0[25] = '{0,2,4,6, 8,8,8,8, 8,8,8,8, 8,6,4,2, 0,0,0,0, 0,0,0,0, 0};
  int tab1[25] = '{0,0,0,0, 0,0,0,0, 0,2,4,6, 8,8,8,8, 8,8,8,8, 8,6,4,2, 0};
  int tab2[25] = '{8,8,8,8, 8,6,4,2, 0,0,0,0, 0,0,0,0, 0,2,4,6, 8,8,8,8, 8};

  initial begin
    int n;
    logic found;
    rst  = 1'b1;
    en   = 1'b1;
    mode = 1'b0;
    sd3  = {4'd0, 4'd15, 4'd3};
    sd4  = {4'd3, 4'd0, 4'd15, 4'd3};
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset_out", 32'(pwm3), 32'd7);
    check("reset_tick", 32'(tick3), 32'd0);
    rst = 1'b0;

    for (int p = 0; p < 25; p++) begin
      count_period();
      check("wheel_ch0", 32'(lows[0]), 32'(tab0[p]));
      check("wheel_ch1", 32'(lows[1]), 32'(tab1[p]));
      check("wheel_ch2", 32'(lows[2]), 32'(tab2[p]));
    end

    repeat (3) @(negedge clk);
    mode = 1'b1;
    wait_tick();
    repeat (2) begin
      count_period();
      check("static_ch0", 32'(lows[0]), 32'd3);
      check("static_ch1", 32'(lows[1]), 32'd8);
      check("static_ch2", 32'(lows[2]), 32'd0);
    end
    repeat (3) @(negedge clk);
    mode = 1'b0;
    wait_tick();
    count_period();
    check("resume_ch0_a", 32'(lows[0]), 32'd5);
    count_period();
    check("resume_ch0_b", 32'(lows[0]), 32'd7);
    count_period();
    check("resume_ch0_c", 32'(lows[0]), 32'd8);

    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("disabled_out", 32'(pwm3), 32'd7);
      check("disabled_tick", 32'(tick3), 32'd0);
    end
    en = 1'b1;
    n = 0;
    while (n < 20 && tick3 !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("resume_remaining", 32'(n), 32'd5);

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      wait_tick();
      if ((m_total / STEPS) % 6 == 3) found = 1'b1;
    end
    check("phase3_reached", 32'(found), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_out", 32'(pwm3), 32'd7);
    check("midreset_tick", 32'(tick3), 32'd0);
    rst = 1'b0;
    for (int p = 0; p < 4; p++) begin
      count_period();
      check("restart_ch0", 32'(lows[0]), 32'(tab0[p]));
      check("restart_ch1", 32'(lows[1]), 32'(tab1[p]));
      check("restart_ch2", 32'(lows[2]), 32'(tab2[p]));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of PWM channels.
REQ-002 SHALL have parameter PWM_INTERVAL, default 1200: clocks per PWM period; full-scale duty.
REQ-003 SHALL have parameter STEP_SIZE, default 12: duty change per PWM period while ramping; PWM_INTERVAL % STEP_SIZE == 0 (elaboration error otherwise).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 inverts pwm_out (LED on = 0).
REQ-005 SHALL define DW = $clog2(PWM_INTERVAL+1) as the duty width.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 en  in  1  1 = run; 0 = freeze all counters and force outputs inactive.
REQ-009 mode  in  1  0 = hue-wheel fade; 1 = static duty.
REQ-010 static_duty  in  NUM_CH*DW  per-channel duty for mode 1; channel k in bits [k*DW +: DW].
REQ-011 pwm_out  out  NUM_CH  registered PWM outputs, polarity per ACTIVE_LOW.
REQ-012 period_tick  out  1  registered; 1 for exactly one clock per completed PWM period.

Function
REQ-013 pwm_cnt SHALL count 0..PWM_INTERVAL-1 and wrap to 0; period boundary = cycle where pwm_cnt == PWM_INTERVAL-1 and en == 1.
REQ-014 period_tick SHALL be asserted in the clock after each period boundary.
REQ-015 step_cnt SHALL count period boundaries 0..STEPS-1, STEPS = PWM_INTERVAL/STEP_SIZE; on wrap, phase (0..5) SHALL advance by 1, 5 wrapping to 0.
REQ-016 Channel k state SHALL be PATTERN[(phase - 2k) mod 6], PATTERN = {UP, HI, HI, DOWN, LO, LO}.
REQ-017 At each period boundary in mode 0: UP adds STEP_SIZE to duty (saturating at PWM_INTERVAL), DOWN subtracts STEP_SIZE (saturating at 0), HI loads PWM_INTERVAL, LO loads 0.
REQ-018 On phase change, the duty of a channel entering UP SHALL start from 0 and of one entering DOWN from PWM_INTERVAL (saturation guarantees continuity).
REQ-019 In mode 1, duty[k] SHALL load min(static_duty[k], PWM_INTERVAL) at each period boundary; phase and step_cnt SHALL hold.
REQ-020 mode changes SHALL take effect only at a period boundary; returning to mode 0 resumes from the held phase/step_cnt, duty reloaded per REQ-017 at the next boundary.
REQ-021 Duty registers SHALL change only at period boundaries (no mid-period glitches).
REQ-022 Raw channel level SHALL be (pwm_cnt < duty[k]); pwm_out[k] = raw XOR ACTIVE_LOW, registered, one clock latency after pwm_cnt.
REQ-023 duty == 0 SHALL yield an inactive output for the whole period; duty == PWM_INTERVAL SHALL yield an active output for the whole period.
REQ-024 en == 0 SHALL hold pwm_cnt, step_cnt, phase and duty, drive pwm_out inactive from the next clock, and hold period_tick at 0; en rising resumes from the held count.
REQ-025 All arithmetic SHALL be at least DW+1 bits wide so saturation never wraps.

Reset
REQ-026 rst SHALL override en and mode, at any cycle including mid-period.
REQ-027 On rst: pwm_cnt = 0, step_cnt = 0, phase = 0, period_tick = 0, pwm_out = all inactive ({NUM_CH{ACTIVE_LOW}}).
REQ-028 On rst: duty[k] = 0 for state UP or LO, PWM_INTERVAL for state HI or DOWN, per REQ-016 at phase 0 (default: ch0 = 0, ch1 = 0, ch2 = PWM_INTERVAL).

Verification (PWM_INTERVAL=8, STEP_SIZE=2, NUM_CH=3, ACTIVE_LOW=1)
REQ-029 Reset released, en=1, mode=0 -> period_tick every 8 clocks; ch2 pwm_out = 0 all period; ch1 = 1 all period; ch0 low for 0,2,4,6 clocks in periods 1..4.
REQ-030 Run 24 periods -> phase sequence 0,1,..,5, then wraps to 0; ch0 duty 8 in phases 1-2, ramps 8->0 in phase 3, stays 0 in phases 4-5.
REQ-031 mode=1 with static_duty ch0=3, ch1=15, ch2=0, toggled mid-period -> from the next boundary ch0 low 3 of 8 clocks, ch1 low 8 of 8 (clamped), ch2 high 8 of 8; phase frozen.
REQ-032 en=0 for 20 clocks mid-period -> pwm_out = 3'b111 and period_tick = 0 throughout; after en=1 the current period completes in the remaining clocks.
REQ-033 rst pulsed at pwm_cnt=5 in phase 3 -> next clock pwm_out = 3'b111, then the REQ-029 sequence restarts exactly.
REQ-034 NUM_CH=4 -> ch3 follows ch0 pattern (offset 6 mod 6 = 0).
